sa_ax_split_arbiter: RTL and testbench
======================================

# sa_ax_split_arbiter

Slave-side address-channel arbiter for the AXI4 interconnect, one instance per slave port. Accepts AW or AR requests from MST_AMT master dispatchers, keeps them in per-master FIFOs, arbitrates with weighted round-robin, and splits INCR bursts at every 4KB boundary, with any number of pieces per burst. Issued pieces leave through a registered slave-side output stage. An order record per piece is sent to the data channel.

## Interface
- MST_AMT, 4: number of masters, ≥2
- OUTSTANDING_AMT, 8: per-master FIFO depth, power of 2
- MST_WEIGHT, {8'd1,…}: flat, 8 bits per master, master 0 in LSBs; weight 0 treated as 1
- ADDR_WIDTH, 32: address width, ≥13
- TRANS_MST_ID_W, 5: master-side ID width
- TRANS_SLV_ID_W, TRANS_MST_ID_W+$clog2(MST_AMT): slave-side ID width
- TRANS_BURST_W, 2: AxBURST width
- TRANS_DATA_LEN_W, 8: AxLEN width
- TRANS_DATA_SIZE_W, 3: AxSIZE width
- SLV_BASE, 0: slave base address
- SLV_MASK, 32'hC000_0000: decode mask
- ACLK_i  in  1  clock; everything on rising edge
- ARESET_i  in  1  reset, synchronous, active-high
- dsp_AxID_i, dsp_AxADDR_i, dsp_AxBURST_i, dsp_AxLEN_i, dsp_AxSIZE_i  in  field width×MST_AMT  flattened dispatcher requests, master 0 in LSBs
- dsp_AxVALID_i  in  MST_AMT  per-master request valid
- dsp_AxREADY_o  out  MST_AMT  per-master accept
- s_AxID_o  out  TRANS_SLV_ID_W  {mst_id, AxID}
- s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o  out  field widths  piece to slave
- s_AxVALID_o  out  1  / s_AxREADY_i  in  1  slave handshake
- ord_mst_id_o  out  $clog2(MST_AMT)  granted master of issued piece
- ord_AxLEN_o  out  TRANS_DATA_LEN_W  piece LEN
- ord_last_o  out  1  piece is the last one of its original transaction
- ord_valid_o  out  1  / ord_ready_i  in  1  data-channel order FIFO write and space available

## Operation
- Decode: hit[m] = (dsp_AxADDR[m] & SLV_MASK) == SLV_BASE. dsp_AxREADY_o[m] = ~fifo_full[m], independent of VALID and hit. A push happens when VALID & hit & READY. Non-hit requests are ignored.
- FIFO: stores {ID, ADDR, BURST, LEN, SIZE}. A pop in the same cycle does not free a slot for that cycle's push. READY stays low when the FIFO is full.
- Arbiter, weighted RR: requests are the non-empty FIFOs.
  - Grant holds on the current master for up to WEIGHT[m] complete original transactions while it keeps requesting.
  - It then moves to the next requesting master in ascending index order, wrapping around, and reloads that master's credit.
  - Arbitration happens only in IDLE, so all pieces of one transaction are issued contiguously.
- Splitter FSM:
  - IDLE: when any request exists, load cur_addr and rem = LEN+1 from the granted FIFO head, then go to SPLIT.
  - SPLIT: issue one piece per issue cycle.
  - INCR piece: aligned = cur_addr with SIZE LSBs cleared. bound = (4096 − aligned[11:0]) >> SIZE. beats = min(rem, bound). Piece ADDR = cur_addr, as given for the first piece. Piece LEN = beats−1.
  - After an INCR piece: cur_addr = aligned + (beats << SIZE), rem −= beats. Width rule: 13-bit intermediates; ADDR_WIDTH wraps modulo.
  - FIXED/WRAP: exactly one piece, unchanged.
  - When rem reaches 0: ord_last_o=1, pop the FIFO, decrement the credit, return to IDLE. The next transaction can be loaded in the following cycle.
- Issue condition: SPLIT & (~s_AxVALID_o | s_AxREADY_i) & ord_ready_i.
  - ord_valid_o = issue condition, combinational.
  - The output register loads {ID, piece fields} on issue.
- Output stage: one register. s_AxVALID_o clears on a handshake with no new issue. Outputs hold stable while VALID & ~READY.

## Timing
- Reset (ARESET_i=1):
  - dsp_AxREADY_o=0, s_AxVALID_o=0, all s_Ax* outputs=0, ord_valid_o=0.
  - FIFOs empty, FSM IDLE, arbiter pointer at master 0, credits = weights.
- After reset deasserts: dsp_AxREADY_o=all-ones in the first cycle.
- Reset mid-split discards all queued and partial transactions.
- Latency: push at edge n gives IDLE load at edge n+1, issue in cycle n+1, and s_AxVALID_o=1 from edge n+2 (2 cycles).
- Throughput: one piece per cycle with READY held high. One IDLE bubble per original transaction.
- ord_ready_i=0 stalls issue. Pieces are never dropped or reordered.

## Test plan
- Single master: M0 ADDR 0x0000_0100, INCR, LEN 3, SIZE 2 -> one piece, ID {0,ID}, LEN 3, ord_last 1, s_AxVALID_o at cycle 2.
- 2-split: ADDR 0x0FF0, SIZE 2, LEN 7 -> (0x0FF0, LEN 3, last 0) then (0x1000, LEN 3, last 1).
- Multi-split: ADDR 0x0F00, SIZE 7, LEN 255 -> 9 pieces in this order:
  - (0x0F00, LEN 1)
  - 7 pieces at 0x1000…0x7000, LEN 31 each
  - (0x8000, LEN 29, last 1)
- WRR: weights M0=3, M1=1, both preloaded with 5 single-piece transactions -> grant order M0×3, M1, M0×2, M1, M1, M1, M1.
- Boundaries:
  - Miss address -> no push.
  - M0 pushes 8 → READY[0]=0.
  - s_AxREADY_i low 5 cycles -> outputs stable.
  - ord_ready_i low -> no issue.
- Reset asserted during piece 4 of multi-split -> next cycle all outputs at reset values; later traffic is normal.

Source files
------------

// File: rtl/sa_ax_split_arbiter_if.sv
// Address-channel bundle between the dispatchers, the slave port and the data-channel order FIFO.
interface sa_ax_split_arbiter_if #(
  parameter int unsigned MST_AMT           = 4,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned TRANS_MST_ID_W    = 5,
  parameter int unsigned TRANS_SLV_ID_W    = TRANS_MST_ID_W + $clog2(MST_AMT),
  parameter int unsigned TRANS_BURST_W     = 2,
  parameter int unsigned TRANS_DATA_LEN_W  = 8,
  parameter int unsigned TRANS_DATA_SIZE_W = 3
);
  localparam int unsigned MID_W = $clog2(MST_AMT);

  logic [TRANS_MST_ID_W*MST_AMT-1:0]    dsp_AxID_i;
  logic [ADDR_WIDTH*MST_AMT-1:0]        dsp_AxADDR_i;
  logic [TRANS_BURST_W*MST_AMT-1:0]     dsp_AxBURST_i;
  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]  dsp_AxLEN_i;
  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0] dsp_AxSIZE_i;
  logic [MST_AMT-1:0]                   dsp_AxVALID_i;
  logic [MST_AMT-1:0]                   dsp_AxREADY_o;

  logic [TRANS_SLV_ID_W-1:0]            s_AxID_o;
  logic [ADDR_WIDTH-1:0]                s_AxADDR_o;
  logic [TRANS_BURST_W-1:0]             s_AxBURST_o;
  logic [TRANS_DATA_LEN_W-1:0]          s_AxLEN_o;
  logic [TRANS_DATA_SIZE_W-1:0]         s_AxSIZE_o;
  logic                                 s_AxVALID_o;
  logic                                 s_AxREADY_i;

  logic [MID_W-1:0]                     ord_mst_id_o;
  logic [TRANS_DATA_LEN_W-1:0]          ord_AxLEN_o;
  logic                                 ord_last_o;
  logic                                 ord_valid_o;
  logic                                 ord_ready_i;

  modport slave (
    input  dsp_AxID_i, dsp_AxADDR_i, dsp_AxBURST_i, dsp_AxLEN_i, dsp_AxSIZE_i, dsp_AxVALID_i,
    output dsp_AxREADY_o,
    output s_AxID_o, s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o, s_AxVALID_o,
    input  s_AxREADY_i,
    output ord_mst_id_o, ord_AxLEN_o, ord_last_o, ord_valid_o,
    input  ord_ready_i
  );

  modport master (
    output dsp_AxID_i, dsp_AxADDR_i, dsp_AxBURST_i, dsp_AxLEN_i, dsp_AxSIZE_i, dsp_AxVALID_i,
    input  dsp_AxREADY_o,
    input  s_AxID_o, s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o, s_AxVALID_o,
    output s_AxREADY_i,
    input  ord_mst_id_o, ord_AxLEN_o, ord_last_o, ord_valid_o,
    output ord_ready_i
  );
endinterface

// File: rtl/sa_ax_split_arbiter.sv
// Slave-port AW/AR arbiter: per-master FIFOs, weighted round-robin grant, 4KB INCR burst splitting,
// registered slave-side output and one order record per issued piece.
module sa_ax_split_arbiter #(
  parameter int unsigned           MST_AMT           = 4,
  parameter int unsigned           OUTSTANDING_AMT   = 8,
  parameter logic [8*MST_AMT-1:0]  MST_WEIGHT        = {MST_AMT{8'd1}},
  parameter int unsigned           ADDR_WIDTH        = 32,
  parameter int unsigned           TRANS_MST_ID_W    = 5,
  parameter int unsigned           TRANS_SLV_ID_W    = TRANS_MST_ID_W + $clog2(MST_AMT),
  parameter int unsigned           TRANS_BURST_W     = 2,
  parameter int unsigned           TRANS_DATA_LEN_W  = 8,
  parameter int unsigned           TRANS_DATA_SIZE_W = 3,
  parameter logic [ADDR_WIDTH-1:0] SLV_BASE          = '0,
  parameter logic [ADDR_WIDTH-1:0] SLV_MASK          = ADDR_WIDTH'(32'hC000_0000)
) (
  input  logic                 ACLK_i,
  input  logic                 ARESET_i,
  sa_ax_split_arbiter_if.slave bus
);
  localparam int unsigned MID_W = $clog2(MST_AMT);
  localparam int unsigned PTR_W = $clog2(OUTSTANDING_AMT);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned REM_W = TRANS_DATA_LEN_W + 1;
  localparam int unsigned BND_W = 13;
  localparam logic [TRANS_BURST_W-1:0] BURST_INCR = TRANS_BURST_W'(1);

  typedef enum logic {IDLE, SPLIT} state_e;

  typedef struct packed {
    logic [TRANS_MST_ID_W-1:0]    id;
    logic [ADDR_WIDTH-1:0]        addr;
    logic [TRANS_BURST_W-1:0]     burst;
    logic [TRANS_DATA_LEN_W-1:0]  len;
    logic [TRANS_DATA_SIZE_W-1:0] size;
  } ax_entry_t;

  function automatic logic [7:0] weight(input int unsigned m);
    logic [7:0] w;
    w = MST_WEIGHT[8*m +: 8];
    return (w == 8'd0) ? 8'd1 : w;
  endfunction

  ax_entry_t                     in_entry [MST_AMT];
  ax_entry_t                     mem_q    [MST_AMT][OUTSTANDING_AMT];
  ax_entry_t                     head;
  logic [MST_AMT-1:0]            hit, full, req, push, pop;
  logic [PTR_W-1:0]              wr_ptr_q [MST_AMT], wr_ptr_d [MST_AMT];
  logic [PTR_W-1:0]              rd_ptr_q [MST_AMT], rd_ptr_d [MST_AMT];
  logic [CNT_W-1:0]              cnt_q    [MST_AMT], cnt_d    [MST_AMT];
  logic [7:0]                    credit_q [MST_AMT], credit_d [MST_AMT];

  state_e                        state_q, state_d;
  logic [MID_W-1:0]              gnt_q, gnt_d, arb_sel, idx;
  logic                          arb_switch, found;
  logic [ADDR_WIDTH-1:0]         cur_addr_q, cur_addr_d, aligned;
  logic [REM_W-1:0]              rem_q, rem_d;
  logic [BND_W-1:0]              bound, beats, rem_ext;
  logic [TRANS_DATA_LEN_W-1:0]   piece_len;
  logic                          piece_last, issue;

  logic                          s_valid_q, s_valid_d;
  logic [TRANS_SLV_ID_W-1:0]     s_id_q, s_id_d;
  logic [ADDR_WIDTH-1:0]         s_addr_q, s_addr_d;
  logic [TRANS_BURST_W-1:0]      s_burst_q, s_burst_d;
  logic [TRANS_DATA_LEN_W-1:0]   s_len_q, s_len_d;
  logic [TRANS_DATA_SIZE_W-1:0]  s_size_q, s_size_d;

  // Unflatten dispatcher requests, decode, and qualify pushes.
  always_comb begin
    for (int unsigned m = 0; m < MST_AMT; m++) begin
      in_entry[m].id    = bus.dsp_AxID_i[m*TRANS_MST_ID_W +: TRANS_MST_ID_W];
      in_entry[m].addr  = bus.dsp_AxADDR_i[m*ADDR_WIDTH +: ADDR_WIDTH];
      in_entry[m].burst = bus.dsp_AxBURST_i[m*TRANS_BURST_W +: TRANS_BURST_W];
      in_entry[m].len   = bus.dsp_AxLEN_i[m*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
      in_entry[m].size  = bus.dsp_AxSIZE_i[m*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
      hit[m]  = (in_entry[m].addr & SLV_MASK) == SLV_BASE;
      full[m] = cnt_q[m] == CNT_W'(OUTSTANDING_AMT);
      req[m]  = cnt_q[m] != '0;
      push[m] = bus.dsp_AxVALID_i[m] & hit[m] & ~full[m] & ~ARESET_i;
    end
  end

  // Fullness comes from the registered count, so a same-cycle pop never admits a push.
  always_comb begin
    for (int unsigned m = 0; m < MST_AMT; m++) begin
      wr_ptr_d[m] = wr_ptr_q[m] + PTR_W'(push[m]);
      rd_ptr_d[m] = rd_ptr_q[m] + PTR_W'(pop[m]);
      cnt_d[m]    = cnt_q[m] + CNT_W'(push[m]) - CNT_W'(pop[m]);
    end
  end

  // Keep the current master while it has credit and requests; otherwise search upward with wrap.
  always_comb begin
    arb_sel    = gnt_q;
    arb_switch = 1'b0;
    found      = 1'b0;
    idx        = gnt_q;
    if (!(req[gnt_q] && credit_q[gnt_q] != 8'd0)) begin
      arb_switch = 1'b1;
      for (int unsigned i = 1; i <= MST_AMT; i++) begin
        idx = MID_W'((32'(gnt_q) + i) % MST_AMT);
        if (!found && req[idx]) begin
          found   = 1'b1;
          arb_sel = idx;
        end
      end
    end
  end

  // Current piece: INCR beats are clipped at the next 4KB page.
  always_comb begin
    head       = mem_q[gnt_q][rd_ptr_q[gnt_q]];
    aligned    = cur_addr_q & ~((ADDR_WIDTH'(1) << head.size) - ADDR_WIDTH'(1));
    bound      = (BND_W'(4096) - BND_W'(aligned[11:0])) >> head.size;
    rem_ext    = BND_W'(rem_q);
    beats      = (head.burst == BURST_INCR && rem_ext > bound) ? bound : rem_ext;
    piece_len  = TRANS_DATA_LEN_W'(beats - BND_W'(1));
    piece_last = beats == rem_ext;
    issue      = (state_q == SPLIT) & (~s_valid_q | bus.s_AxREADY_i) & bus.ord_ready_i;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    credit_d   = credit_q;
    pop        = '0;
    s_valid_d  = s_valid_q;
    s_id_d     = s_id_q;
    s_addr_d   = s_addr_q;
    s_burst_d  = s_burst_q;
    s_len_d    = s_len_q;
    s_size_d   = s_size_q;
    if (bus.s_AxREADY_i) s_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d      = arb_sel;
          cur_addr_d = mem_q[arb_sel][rd_ptr_q[arb_sel]].addr;
          rem_d      = REM_W'(mem_q[arb_sel][rd_ptr_q[arb_sel]].len) + REM_W'(1);
          if (arb_switch) credit_d[arb_sel] = weight(32'(arb_sel));
          state_d    = SPLIT;
        end
      end
      SPLIT: begin
        if (issue) begin
          s_valid_d  = 1'b1;
          s_id_d     = TRANS_SLV_ID_W'({gnt_q, head.id});
          s_addr_d   = cur_addr_q;
          s_burst_d  = head.burst;
          s_len_d    = piece_len;
          s_size_d   = head.size;
          cur_addr_d = aligned + ADDR_WIDTH'(beats << head.size);
          rem_d      = rem_q - REM_W'(beats);
          if (piece_last) begin
            pop[gnt_q]      = 1'b1;
            credit_d[gnt_q] = credit_q[gnt_q] - 8'd1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      cur_addr_q <= '0;
      rem_q      <= '0;
      s_valid_q  <= 1'b0;
      s_id_q     <= '0;
      s_addr_q   <= '0;
      s_burst_q  <= '0;
      s_len_q    <= '0;
      s_size_q   <= '0;
      for (int unsigned m = 0; m < MST_AMT; m++) begin
        wr_ptr_q[m] <= '0;
        rd_ptr_q[m] <= '0;
        cnt_q[m]    <= '0;
        credit_q[m] <= weight(m);
      end
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      s_valid_q  <= s_valid_d;
      s_id_q     <= s_id_d;
      s_addr_q   <= s_addr_d;
      s_burst_q  <= s_burst_d;
      s_len_q    <= s_len_d;
      s_size_q   <= s_size_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      credit_q   <= credit_d;
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the counters.
  always_ff @(posedge ACLK_i) begin
    for (int unsigned m = 0; m < MST_AMT; m++) begin
      if (push[m]) mem_q[m][wr_ptr_q[m]] <= in_entry[m];
    end
  end

  assign bus.dsp_AxREADY_o = ~full & {MST_AMT{~ARESET_i}};
  assign bus.s_AxVALID_o   = s_valid_q;
  assign bus.s_AxID_o      = s_id_q;
  assign bus.s_AxADDR_o    = s_addr_q;
  assign bus.s_AxBURST_o   = s_burst_q;
  assign bus.s_AxLEN_o     = s_len_q;
  assign bus.s_AxSIZE_o    = s_size_q;
  assign bus.ord_mst_id_o  = gnt_q;
  assign bus.ord_AxLEN_o   = piece_len;
  assign bus.ord_last_o    = piece_last;
  assign bus.ord_valid_o   = issue & ~ARESET_i;
endmodule

// File: tb/tb_sa_ax_split_arbiter.sv
// Scoreboard bench for sa_ax_split_arbiter: expected pieces are queued as requests are driven
// and checked against the slave handshake and the order-record port.
module tb_sa_ax_split_arbiter;
  logic clk;
  logic areset;
  int   checks   = 0;
  int   failures = 0;
  int   hs_cnt   = 0;

  typedef struct {
    logic [6:0]  id;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [2:0]  size;
    logic        last;
    logic [1:0]  mst;
  } piece_t;

  piece_t s_q[$];
  piece_t o_q[$];
  piece_t s_exp, o_exp;

  sa_ax_split_arbiter_if #(.MST_AMT(4), .ADDR_WIDTH(32), .TRANS_MST_ID_W(5)) bus ();

  sa_ax_split_arbiter #(
    .MST_AMT(4), .OUTSTANDING_AMT(8), .MST_WEIGHT({8'd1, 8'd1, 8'd1, 8'd3}),
    .ADDR_WIDTH(32), .TRANS_MST_ID_W(5)
  ) dut (
    .ACLK_i  (clk),
    .ARESET_i(areset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are checked at the falling edge, half a cycle away from any update.
  always @(negedge clk) begin
    if (bus.ord_valid_o) begin
      checks++;
      if (o_q.size() == 0) begin
        failures++;
        $display("FAIL ord_unexpected got mst=%0d len=%0d last=%0b", bus.ord_mst_id_o, bus.ord_AxLEN_o, bus.ord_last_o);
      end else begin
        o_exp = o_q.pop_front();
        if ({bus.ord_mst_id_o, bus.ord_AxLEN_o, bus.ord_last_o} !== {o_exp.mst, o_exp.len, o_exp.last}) begin
          failures++;
          $display("FAIL ord_record got mst=%0d len=%0d last=%0b exp mst=%0d len=%0d last=%0b",
                   bus.ord_mst_id_o, bus.ord_AxLEN_o, bus.ord_last_o, o_exp.mst, o_exp.len, o_exp.last);
        end
      end
    end
    if (bus.s_AxVALID_o && bus.s_AxREADY_i) begin
      hs_cnt++;
      checks++;
      if (s_q.size() == 0) begin
        failures++;
        $display("FAIL s_unexpected got id=%h addr=%h len=%0d", bus.s_AxID_o, bus.s_AxADDR_o, bus.s_AxLEN_o);
      end else begin
        s_exp = s_q.pop_front();
        if ({bus.s_AxID_o, bus.s_AxADDR_o, bus.s_AxBURST_o, bus.s_AxLEN_o, bus.s_AxSIZE_o} !==
            {s_exp.id, s_exp.addr, s_exp.burst, s_exp.len, s_exp.size}) begin
          failures++;
          $display("FAIL s_piece got id=%h addr=%h burst=%0d len=%0d size=%0d exp id=%h addr=%h burst=%0d len=%0d size=%0d",
                   bus.s_AxID_o, bus.s_AxADDR_o, bus.s_AxBURST_o, bus.s_AxLEN_o, bus.s_AxSIZE_o,
                   s_exp.id, s_exp.addr, s_exp.burst, s_exp.len, s_exp.size);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [4:0] id, input logic [31:0] addr,
                         input logic [1:0] burst, input logic [7:0] len, input logic [2:0] size);
    bus.dsp_AxID_i[m*5 +: 5]    = id;
    bus.dsp_AxADDR_i[m*32 +: 32] = addr;
    bus.dsp_AxBURST_i[m*2 +: 2] = burst;
    bus.dsp_AxLEN_i[m*8 +: 8]   = len;
    bus.dsp_AxSIZE_i[m*3 +: 3]  = size;
    bus.dsp_AxVALID_i[m]        = 1'b1;
  endtask

  task automatic step_push();
    tick();
    bus.dsp_AxVALID_i = '0;
  endtask

  // Reference splitter: walk the burst page by page in byte addresses.
  task automatic expect_tx(input int m, input logic [4:0] id, input logic [31:0] addr,
                           input logic [1:0] burst, input logic [7:0] len, input logic [2:0] size);
    longint unsigned a, rem, bytes, aligned, page_end, n;
    piece_t p;
    a = 64'(addr);
    rem = 64'(len) + 1;
    bytes = 64'd1 << size;
    while (rem > 0) begin
      aligned = a;
      n = rem;
      if (burst == 2'b01) begin
        aligned  = a & ~(bytes - 1);
        page_end = (aligned & ~64'hFFF) + 64'd4096;
        n        = (page_end - aligned) / bytes;
        if (n > rem) n = rem;
      end
      p.mst   = 2'(m);
      p.id    = {2'(m), id};
      p.addr  = 32'(a);
      p.burst = burst;
      p.len   = 8'(n - 1);
      p.size  = size;
      p.last  = (n == rem);
      s_q.push_back(p);
      o_q.push_back(p);
      rem = rem - n;
      a   = aligned + n * bytes;
    end
  endtask

  task automatic wait_drain(output int left);
    for (int c = 0; c < 400; c++) begin
      if (s_q.size() == 0 && o_q.size() == 0) break;
      tick();
    end
    left = s_q.size() + o_q.size();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.dsp_AxREADY_o !== 4'h0) begin failures++; $display("FAIL rst_ready got %b exp 0000", bus.dsp_AxREADY_o); end
    checks++;
    if ({bus.s_AxVALID_o, bus.ord_valid_o} !== 2'b00) begin
      failures++; $display("FAIL rst_valid got s=%b ord=%b exp 0", bus.s_AxVALID_o, bus.ord_valid_o);
    end
    checks++;
    if ({bus.s_AxID_o, bus.s_AxADDR_o, bus.s_AxBURST_o, bus.s_AxLEN_o, bus.s_AxSIZE_o} !== '0) begin
      failures++; $display("FAIL rst_fields got id=%h addr=%h len=%0d exp 0", bus.s_AxID_o, bus.s_AxADDR_o, bus.s_AxLEN_o);
    end
    areset = 1'b0;
    #1;
    checks++;
    if (bus.dsp_AxREADY_o !== 4'hF) begin failures++; $display("FAIL post_rst_ready got %b exp 1111", bus.dsp_AxREADY_o); end
    tick();
  endtask

  task automatic test_single();
    int left;
    set_req(0, 5'd5, 32'h0000_0100, 2'b01, 8'd3, 3'd2);
    expect_tx(0, 5'd5, 32'h0000_0100, 2'b01, 8'd3, 3'd2);
    step_push();
    checks++;
    if ({bus.s_AxVALID_o, bus.ord_valid_o} !== 2'b00) begin
      failures++; $display("FAIL lat_c0 got s=%b ord=%b exp 00", bus.s_AxVALID_o, bus.ord_valid_o);
    end
    tick();
    checks++;
    if ({bus.s_AxVALID_o, bus.ord_valid_o} !== 2'b01) begin
      failures++; $display("FAIL lat_c1 got s=%b ord=%b exp 01", bus.s_AxVALID_o, bus.ord_valid_o);
    end
    tick();
    checks++;
    if (bus.s_AxVALID_o !== 1'b1) begin failures++; $display("FAIL lat_c2 got s=%b exp 1", bus.s_AxVALID_o); end
    wait_drain(left);
    checks++;
    if (left != 0) begin failures++; $display("FAIL single_drain left=%0d exp 0", left); end
    tick();
  endtask

  task automatic test_split2();
    int left;
    set_req(0, 5'd7, 32'h0000_0FF0, 2'b01, 8'd7, 3'd2);
    expect_tx(0, 5'd7, 32'h0000_0FF0, 2'b01, 8'd7, 3'd2);
    step_push();
    wait_drain(left);
    checks++;
    if (left != 0) begin failures++; $display("FAIL split2_drain left=%0d exp 0", left); end
    tick();
  endtask

  task automatic test_back_to_back();
    int left;
    int c;
    set_req(0, 5'd9, 32'h0000_0F00, 2'b01, 8'd255, 3'd7);
    expect_tx(0, 5'd9, 32'h0000_0F00, 2'b01, 8'd255, 3'd7);
    step_push();
    for (c = 0; c < 10 && !bus.s_AxVALID_o; c++) tick();
    checks++;
    if (bus.s_AxVALID_o !== 1'b1) begin failures++; $display("FAIL multi_start got s=%b exp 1", bus.s_AxVALID_o); end
    for (int k = 1; k < 9; k++) begin
      tick();
      checks++;
      if (bus.s_AxVALID_o !== 1'b1) begin failures++; $display("FAIL multi_stream piece=%0d got s=%b exp 1", k, bus.s_AxVALID_o); end
    end
    tick();
    checks++;
    if (bus.s_AxVALID_o !== 1'b0) begin failures++; $display("FAIL multi_end got s=%b exp 0", bus.s_AxVALID_o); end
    wait_drain(left);
    checks++;
    if (left != 0) begin failures++; $display("FAIL multi_drain left=%0d exp 0", left); end
  endtask

  task automatic test_miss();
    set_req(0, 5'd1, 32'h4000_0100, 2'b01, 8'd0, 3'd2);
    step_push();
    repeat (5) tick();
    checks++;
    if (bus.s_AxVALID_o !== 1'b0) begin failures++; $display("FAIL miss_valid got s=%b exp 0", bus.s_AxVALID_o); end
    checks++;
    if (bus.dsp_AxREADY_o !== 4'hF) begin failures++; $display("FAIL miss_ready got %b exp 1111", bus.dsp_AxREADY_o); end
  endtask

  task automatic test_full_stall();
    int left;
    int c;
    bus.ord_ready_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_req(0, 5'(k), 32'h0000_2000 + 32'(k * 16), 2'b01, 8'd0, 3'd2);
      expect_tx(0, 5'(k), 32'h0000_2000 + 32'(k * 16), 2'b01, 8'd0, 3'd2);
      step_push();
    end
    checks++;
    if (bus.dsp_AxREADY_o !== 4'b1110) begin failures++; $display("FAIL full_ready got %b exp 1110", bus.dsp_AxREADY_o); end
    set_req(0, 5'd20, 32'h0000_2F00, 2'b01, 8'd0, 3'd2);
    step_push();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus.s_AxVALID_o, bus.ord_valid_o} !== 2'b00) begin
        failures++; $display("FAIL ord_stall cyc=%0d got s=%b ord=%b exp 00", k, bus.s_AxVALID_o, bus.ord_valid_o);
      end
      tick();
    end
    bus.s_AxREADY_i = 1'b0;
    bus.ord_ready_i = 1'b1;
    for (c = 0; c < 10 && !bus.s_AxVALID_o; c++) tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus.s_AxVALID_o, bus.s_AxID_o, bus.s_AxADDR_o, bus.s_AxLEN_o} !== {1'b1, 7'h00, 32'h0000_2000, 8'd0}) begin
        failures++; $display("FAIL s_stall cyc=%0d got v=%b id=%h addr=%h len=%0d exp v=1 id=00 addr=00002000 len=0",
                             k, bus.s_AxVALID_o, bus.s_AxID_o, bus.s_AxADDR_o, bus.s_AxLEN_o);
      end
      tick();
    end
    bus.s_AxREADY_i = 1'b1;
    wait_drain(left);
    checks++;
    if (left != 0) begin failures++; $display("FAIL full_drain left=%0d exp 0", left); end
    tick();
  endtask

  task automatic test_wrr();
    int left;
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    for (int k = 0; k < 3; k++) expect_tx(0, 5'(k), 32'h0000_3000 + 32'(k * 64), 2'b01, 8'd0, 3'd2);
    expect_tx(1, 5'd0, 32'h0000_3800, 2'b01, 8'd0, 3'd2);
    for (int k = 3; k < 5; k++) expect_tx(0, 5'(k), 32'h0000_3000 + 32'(k * 64), 2'b01, 8'd0, 3'd2);
    for (int k = 1; k < 5; k++) expect_tx(1, 5'(k), 32'h0000_3800 + 32'(k * 64), 2'b01, 8'd0, 3'd2);
    for (int k = 0; k < 5; k++) begin
      set_req(0, 5'(k), 32'h0000_3000 + 32'(k * 64), 2'b01, 8'd0, 3'd2);
      set_req(1, 5'(k), 32'h0000_3800 + 32'(k * 64), 2'b01, 8'd0, 3'd2);
      step_push();
    end
    wait_drain(left);
    checks++;
    if (left != 0) begin failures++; $display("FAIL wrr_drain left=%0d exp 0", left); end
    tick();
  endtask

  task automatic test_reset_mid();
    int left;
    int c;
    hs_cnt = 0;
    set_req(2, 5'd3, 32'h0000_0F00, 2'b01, 8'd255, 3'd7);
    expect_tx(2, 5'd3, 32'h0000_0F00, 2'b01, 8'd255, 3'd7);
    step_push();
    for (c = 0; c < 100 && hs_cnt < 3; c++) @(posedge clk);
    #1;
    checks++;
    if (hs_cnt != 3) begin failures++; $display("FAIL rmid_pieces got %0d exp 3", hs_cnt); end
    areset = 1'b1;
    tick();
    checks++;
    if ({bus.s_AxVALID_o, bus.ord_valid_o, bus.dsp_AxREADY_o} !== 6'b0) begin
      failures++; $display("FAIL rmid_ctrl got s=%b ord=%b rdy=%b exp 0", bus.s_AxVALID_o, bus.ord_valid_o, bus.dsp_AxREADY_o);
    end
    checks++;
    if ({bus.s_AxID_o, bus.s_AxADDR_o, bus.s_AxLEN_o, bus.s_AxSIZE_o, bus.s_AxBURST_o} !== '0) begin
      failures++; $display("FAIL rmid_fields got addr=%h len=%0d exp 0", bus.s_AxADDR_o, bus.s_AxLEN_o);
    end
    s_q.delete();
    o_q.delete();
    tick();
    areset = 1'b0;
    tick();
    set_req(1, 5'd11, 32'h0000_1FF8, 2'b01, 8'd3, 3'd2);
    expect_tx(1, 5'd11, 32'h0000_1FF8, 2'b01, 8'd3, 3'd2);
    step_push();
    wait_drain(left);
    checks++;
    if (left != 0) begin failures++; $display("FAIL rmid_after left=%0d exp 0", left); end
    repeat (3) tick();
  endtask

  initial begin
    areset                = 1'b1;
    bus.dsp_AxID_i        = '0;
    bus.dsp_AxADDR_i      = '0;
    bus.dsp_AxBURST_i     = '0;
    bus.dsp_AxLEN_i       = '0;
    bus.dsp_AxSIZE_i      = '0;
    bus.dsp_AxVALID_i     = '0;
    bus.s_AxREADY_i       = 1'b1;
    bus.ord_ready_i       = 1'b1;
    test_reset();
    test_single();
    test_split2();
    test_back_to_back();
    test_miss();
    test_full_stall();
    test_wrr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
